// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between a master (VIP or bench) and the memory responder.
// Channel signals keep their AXI names so waveforms read like the protocol.
interface axi_mem_responder_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Write address channel
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [7:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWLOCK;
    logic [3:0]          AWCACHE;
    logic [2:0]          AWPROT;
    logic [3:0]          AWQOS;
    logic [3:0]          AWREGION;
    logic                AWVALID;
    logic                AWREADY;

    // Write data channel
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    // Write response channel
    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    // Read address channel
    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARLOCK;
    logic [3:0]          ARCACHE;
    logic [2:0]          ARPROT;
    logic [3:0]          ARQOS;
    logic [3:0]          ARREGION;
    logic                ARVALID;
    logic                ARREADY;

    // Read data channel
    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
               AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
               ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
               AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
               ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a word-addressed RAM.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding burst each.
// FIXED/INCR/WRAP bursts up to 256 beats; illegal requests answer SLVERR but
// still move the full beat count so the master never stalls.
module axi_mem_responder #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_mem_responder_if.slave bus
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BYTE_W = $clog2(BYTES);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Address of the following beat; WRAP keeps the bits above the container fixed
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [2:0]        size,
        input logic [7:0]        len,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] incr;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << size;
        incr = addr + step;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | (incr & mask);
            default: next_addr = incr;
        endcase
    endfunction

    // Whole-burst errors that can be decided from the address phase alone
    function automatic logic req_error(
        input logic [2:0] size,
        input logic [7:0] len,
        input logic [1:0] burst
    );
        logic bad_burst;
        logic bad_size;
        logic bad_wrap;
        bad_burst = (burst == 2'b11);
        bad_size  = (size > 3'(BYTE_W));
        bad_wrap  = (burst == 2'b10) &&
                    !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        req_error = bad_burst | bad_size | bad_wrap;
    endfunction

    function automatic logic addr_error(input logic [ADDR_W-1:0] addr);
        addr_error = ({1'b0, addr} >= LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        word_index = addr[BYTE_W +: IDX_W];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write path ----------------
    w_state_t          w_state;
    w_state_t          w_state_next;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic [7:0]        w_cnt;
    logic              w_req_err;
    logic              w_err;
    logic              aw_hs;
    logic              w_hs;
    logic              w_beat_ok;

    assign aw_hs     = (w_state == W_IDLE) && bus.AWVALID;
    assign w_hs      = (w_state == W_DATA) && bus.WVALID;
    assign w_beat_ok = ARESETn && w_hs && !w_req_err && !addr_error(w_addr);

    // Write FSM state register
    always_ff @(posedge ACLK) begin
        if (!ARESETn) w_state <= W_IDLE;
        else          w_state <= w_state_next;
    end

    // Write FSM next state and channel handshake outputs
    always_comb begin
        w_state_next = w_state;
        bus.AWREADY  = 1'b0;
        bus.WREADY   = 1'b0;
        bus.BVALID   = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.AWREADY = 1'b1;
                if (bus.AWVALID) w_state_next = W_DATA;
            end
            W_DATA: begin
                bus.WREADY = 1'b1;
                if (bus.WVALID && (w_cnt == w_len)) w_state_next = W_RESP;
            end
            W_RESP: begin
                bus.BVALID = 1'b1;
                if (bus.BREADY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign bus.BID   = w_id;
    assign bus.BRESP = w_err ? RESP_SLVERR : RESP_OKAY;

    // Write burst bookkeeping; w_err collects every reason for SLVERR
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_id      <= '0;
            w_addr    <= '0;
            w_len     <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            w_cnt     <= '0;
            w_req_err <= 1'b0;
            w_err     <= 1'b0;
        end else if (aw_hs) begin
            w_id      <= bus.AWID;
            w_addr    <= bus.AWADDR;
            w_len     <= bus.AWLEN;
            w_size    <= bus.AWSIZE;
            w_burst   <= bus.AWBURST;
            w_cnt     <= '0;
            w_req_err <= req_error(bus.AWSIZE, bus.AWLEN, bus.AWBURST);
            w_err     <= req_error(bus.AWSIZE, bus.AWLEN, bus.AWBURST);
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            w_err  <= w_err | addr_error(w_addr) | (bus.WLAST != (w_cnt == w_len));
        end
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge ACLK) begin
        if (w_beat_ok) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.WSTRB[b]) mem[word_index(w_addr)][8*b +: 8] <= bus.WDATA[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t          r_state;
    r_state_t          r_state_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_cnt;
    logic              r_req_err;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              ar_hs;
    logic              r_hs;
    logic              r_at_last;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_err;

    assign ar_hs     = (r_state == R_IDLE) && bus.ARVALID;
    assign r_hs      = (r_state == R_DATA) && bus.RREADY;
    assign r_at_last = (r_cnt == r_len);

    // Read FSM state register
    always_ff @(posedge ACLK) begin
        if (!ARESETn) r_state <= R_IDLE;
        else          r_state <= r_state_next;
    end

    // Read FSM next state and channel handshake outputs
    always_comb begin
        r_state_next = r_state;
        bus.ARREADY  = 1'b0;
        bus.RVALID   = 1'b0;
        bus.RLAST    = 1'b0;
        case (r_state)
            R_IDLE: begin
                bus.ARREADY = 1'b1;
                if (bus.ARVALID) r_state_next = R_DATA;
            end
            R_DATA: begin
                bus.RVALID = 1'b1;
                bus.RLAST  = r_at_last;
                if (bus.RREADY && r_at_last) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Address and error status of the beat that will be loaded into r_data
    always_comb begin
        rd_addr = next_addr(r_addr, r_size, r_len, r_burst);
        rd_err  = r_req_err | addr_error(rd_addr);
        if (ar_hs) begin
            rd_addr = bus.ARADDR;
            rd_err  = req_error(bus.ARSIZE, bus.ARLEN, bus.ARBURST) | addr_error(bus.ARADDR);
        end
    end

    assign bus.RID   = r_id;
    assign bus.RDATA = r_data;
    assign bus.RRESP = r_resp;

    // Read burst bookkeeping and registered RAM read (sees pre-write data)
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
            r_req_err <= 1'b0;
            r_data    <= '0;
            r_resp    <= RESP_OKAY;
        end else if (ar_hs || (r_hs && !r_at_last)) begin
            if (ar_hs) begin
                r_id      <= bus.ARID;
                r_len     <= bus.ARLEN;
                r_size    <= bus.ARSIZE;
                r_burst   <= bus.ARBURST;
                r_cnt     <= '0;
                r_req_err <= req_error(bus.ARSIZE, bus.ARLEN, bus.ARBURST);
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_addr <= rd_addr;
            r_data <= rd_err ? '0 : mem[word_index(rd_addr)];
            r_resp <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    logic unused_sidebands;
    assign unused_sidebands = &{1'b0,
                                bus.AWLOCK, bus.AWCACHE, bus.AWPROT, bus.AWQOS, bus.AWREGION,
                                bus.ARLOCK, bus.ARCACHE, bus.ARPROT, bus.ARQOS, bus.ARREGION};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: hand-computed bursts, error cases,
// back-pressure and reset in the middle of a read burst.
module tb_axi_mem_responder;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    axi_mem_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_mem_responder #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .ACLK(clk),
        .ARESETn(rstn),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrbuf [16];
    logic        rlbuf [16];
    logic [1:0]  bresp;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input string name, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input int early_last, output logic [1:0] resp);
        checkOutput({name, "_awready"}, 64'(bus.AWREADY), 64'd1);
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            checkOutput($sformatf("%s_wready%0d", name, b), 64'(bus.WREADY), 64'd1);
            checkOutput($sformatf("%s_bidle%0d", name, b), 64'(bus.BVALID), 64'd0);
            bus.WDATA = wbuf[b];
            bus.WSTRB = sbuf[b];
            bus.WLAST = (early_last >= 0) ? (b == early_last) : (b == int'(len));
            bus.WVALID = 1'b1;
            tick();
        end
        bus.WVALID = 1'b0;
        bus.WLAST = 1'b0;
        checkOutput({name, "_bvalid"}, 64'(bus.BVALID), 64'd1);
        checkOutput({name, "_bid"}, 64'(bus.BID), 64'(id));
        resp = bus.BRESP;
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        checkOutput({name, "_bdone"}, 64'(bus.BVALID), 64'd0);
    endtask

    task automatic axi_read(input string name, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input int stall_beat);
        checkOutput({name, "_arready"}, 64'(bus.ARREADY), 64'd1);
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        bus.RREADY = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            checkOutput($sformatf("%s_rvalid%0d", name, b), 64'(bus.RVALID), 64'd1);
            checkOutput($sformatf("%s_rid%0d", name, b), 64'(bus.RID), 64'(id));
            rbuf[b]  = bus.RDATA;
            rrbuf[b] = bus.RRESP;
            rlbuf[b] = bus.RLAST;
            if (b == stall_beat) begin
                bus.RREADY = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    checkOutput($sformatf("%s_stall_rvalid%0d", name, s), 64'(bus.RVALID), 64'd1);
                    checkOutput($sformatf("%s_stall_rdata%0d", name, s), 64'(bus.RDATA), 64'(rbuf[b]));
                    checkOutput($sformatf("%s_stall_rlast%0d", name, s), 64'(bus.RLAST), 64'(rlbuf[b]));
                end
                bus.RREADY = 1'b1;
            end
            tick();
        end
        bus.RREADY = 1'b0;
        checkOutput({name, "_rdone"}, 64'(bus.RVALID), 64'd0);
        checkOutput({name, "_arready_back"}, 64'(bus.ARREADY), 64'd1);
    endtask

    task automatic expect_beats(input string name, input logic [7:0] len,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [1:0] resp);
        logic [31:0] exp [4];
        exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3;
        for (int b = 0; b <= int'(len); b++) begin
            checkOutput($sformatf("%s_rdata%0d", name, b), 64'(rbuf[b]), 64'(exp[b]));
            checkOutput($sformatf("%s_rresp%0d", name, b), 64'(rrbuf[b]), 64'(resp));
            checkOutput($sformatf("%s_rlast%0d", name, b), 64'(rlbuf[b]), 64'(b == int'(len)));
        end
    endtask

    task automatic applyStimulus();
        // reset values
        repeat (3) tick();
        rstn = 1'b1;
        checkOutput("rst_awready", 64'(bus.AWREADY), 64'd1);
        checkOutput("rst_arready", 64'(bus.ARREADY), 64'd1);
        checkOutput("rst_wready", 64'(bus.WREADY), 64'd0);
        checkOutput("rst_bvalid", 64'(bus.BVALID), 64'd0);
        checkOutput("rst_rvalid", 64'(bus.RVALID), 64'd0);
        checkOutput("rst_rdata", 64'(bus.RDATA), 64'd0);
        tick();

        // word 0 gets a marker so the out-of-range write can be checked later
        wbuf[0] = 32'hC0FFEE00; sbuf[0] = 4'hF;
        axi_write("w0", 4'h1, 32'h0, 8'd0, 3'd2, 2'b01, -1, bresp);
        checkOutput("w0_bresp", 64'(bresp), 64'd0);

        // INCR write of four words at 0x10
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
        axi_write("wincr", 4'h5, 32'h10, 8'd3, 3'd2, 2'b01, -1, bresp);
        checkOutput("wincr_bresp", 64'(bresp), 64'd0);

        axi_read("rincr", 4'h6, 32'h10, 8'd3, 3'd2, 2'b01, -1);
        expect_beats("rincr", 8'd3, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00);

        // WRAP from 0x18 visits words 6,7,4,5
        axi_read("rwrap", 4'h7, 32'h18, 8'd3, 3'd2, 2'b10, -1);
        expect_beats("rwrap", 8'd3, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 2'b00);

        // FIXED write leaves only the last beat in the single word
        wbuf[0] = 32'h0; wbuf[1] = 32'h0; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        axi_write("wclr", 4'h2, 32'h40, 8'd1, 3'd2, 2'b01, -1, bresp);
        wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2;
        sbuf[0] = 4'hF; sbuf[1] = 4'hF; sbuf[2] = 4'hF;
        axi_write("wfix", 4'h3, 32'h40, 8'd2, 3'd2, 2'b00, -1, bresp);
        checkOutput("wfix_bresp", 64'(bresp), 64'd0);
        axi_read("rfix", 4'h3, 32'h40, 8'd1, 3'd2, 2'b01, -1);
        expect_beats("rfix", 8'd1, 32'hB2, 32'h0, 32'h0, 32'h0, 2'b00);

        // byte strobes
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        axi_write("wff", 4'h4, 32'h80, 8'd0, 3'd2, 2'b01, -1, bresp);
        wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
        axi_write("wstrb", 4'h4, 32'h80, 8'd0, 3'd2, 2'b01, -1, bresp);
        checkOutput("wstrb_bresp", 64'(bresp), 64'd0);
        axi_read("rstrb", 4'h4, 32'h80, 8'd0, 3'd2, 2'b01, -1);
        expect_beats("rstrb", 8'd0, 32'hFF22FF44, 32'h0, 32'h0, 32'h0, 2'b00);

        // out-of-range write aliases to word 0 but must not touch it
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        axi_write("woor", 4'h9, 32'h400, 8'd0, 3'd2, 2'b01, -1, bresp);
        checkOutput("woor_bresp", 64'(bresp), 64'd2);
        axi_read("roor", 4'h9, 32'h0, 8'd0, 3'd2, 2'b01, -1);
        expect_beats("roor", 8'd0, 32'hC0FFEE00, 32'h0, 32'h0, 32'h0, 2'b00);

        // reserved burst type and oversized beat
        axi_read("rbad", 4'hA, 32'h10, 8'd1, 3'd2, 2'b11, -1);
        expect_beats("rbad", 8'd1, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10);
        axi_read("rsize", 4'hB, 32'h10, 8'd0, 3'd3, 2'b01, -1);
        expect_beats("rsize", 8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10);

        // back-pressure on beat 1
        axi_read("rstall", 4'hC, 32'h10, 8'd3, 3'd2, 2'b01, 1);
        expect_beats("rstall", 8'd3, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00);

        // early WLAST: all four beats still taken, SLVERR reported
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hE0 + 32'(i); sbuf[i] = 4'hF; end
        axi_write("wlast", 4'hD, 32'hC0, 8'd3, 3'd2, 2'b01, 1, bresp);
        checkOutput("wlast_bresp", 64'(bresp), 64'd2);

        // reset while beat 2 of a read is on the bus
        bus.ARID = 4'hE; bus.ARADDR = 32'h10; bus.ARLEN = 8'd3; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01;
        bus.ARVALID = 1'b1;
        bus.RREADY = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        tick();
        tick();
        checkOutput("rrst_beat2", 64'(bus.RDATA), 64'hA2);
        rstn = 1'b0;
        tick();
        checkOutput("rrst_rvalid", 64'(bus.RVALID), 64'd0);
        checkOutput("rrst_rdata", 64'(bus.RDATA), 64'd0);
        rstn = 1'b1;
        bus.RREADY = 1'b0;
        tick();
        checkOutput("rrst_arready", 64'(bus.ARREADY), 64'd1);
        axi_read("rpost", 4'h1, 32'h80, 8'd0, 3'd2, 2'b01, -1);
        expect_beats("rpost", 8'd0, 32'hFF22FF44, 32'h0, 32'h0, 32'h0, 2'b00);
        axi_read("rpost2", 4'h2, 32'h10, 8'd1, 3'd2, 2'b01, -1);
        expect_beats("rpost2", 8'd1, 32'hA0, 32'hA1, 32'h0, 32'h0, 2'b00);
    endtask

    // Master side idles, then the directed sequence runs once
    initial begin
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWLOCK = 1'b1; bus.AWCACHE = 4'h3; bus.AWPROT = 3'h2; bus.AWQOS = 4'h1; bus.AWREGION = 4'h2;
        bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
        bus.ARLOCK = 1'b1; bus.ARCACHE = 4'h3; bus.ARPROT = 3'h2; bus.ARQOS = 4'h1; bus.ARREGION = 4'h2;
        bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        #1;
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence ever wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
